// File: rtl/video_pixel_aligner.sv
// video_pixel_aligner: locks an upstream pixel stream (with start-of-frame
// marker) to the raster from the timing generator, buffering pixels in a
// small FIFO and emitting registered sync/de/pixel/coordinates plus error
// pulses for underflow, frame misalignment and wrong line length.
module video_pixel_aligner #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int PIX_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        de_in,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [PIX_W-1:0]            s_data,
    input  logic                        s_sof,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        data_en,
    output logic [PIX_W-1:0]            pixel,
    output logic [$clog2(H_ACTIVE)-1:0] x,
    output logic [$clog2(V_ACTIVE)-1:0] y,
    output logic                        underflow,
    output logic                        resync,
    output logic                        geom_err
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int CW = XW + 1;             // line counter with room to exceed H_ACTIVE
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {HUNT, ARMED, RUN} state_t;

    state_t            state, state_n;
    logic [PIX_W:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [OW-1:0]     occ;
    logic              full, empty;
    logic              push, pop, flush;
    logic              under_d, resync_d;
    logic [PIX_W-1:0]  pix_d;
    logic [PIX_W:0]    head;
    logic [CW-1:0]     cnt;
    logic [YW-1:0]     y_in;
    logic              de_d, vs_d;
    logic              de_fall, vs_rise, at_origin;

    assign full      = (occ == OW'(FIFO_DEPTH));
    assign empty     = (occ == '0);
    assign head      = mem[rd_ptr];
    assign de_fall   = de_d && !de_in;
    assign vs_rise   = vsync_in && !vs_d;
    assign at_origin = (cnt == '0) && (y_in == '0);

    // Upstream ready: always open while hunting, otherwise limited by room.
    always_comb begin
        s_ready = !rst && ((state == HUNT) || !full);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_n;
    end

    // Next state, FIFO push/pop/flush and the pixel/error values to register.
    always_comb begin
        state_n  = state;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        under_d  = 1'b0;
        resync_d = 1'b0;
        pix_d    = '0;
        case (state)
            HUNT: begin
                // Non-sof beats are acknowledged but never written.
                if (s_valid && s_sof) begin
                    push    = 1'b1;
                    state_n = ARMED;
                end
            end
            ARMED: begin
                push = s_valid && !full;
                if (vs_rise) state_n = RUN;
            end
            RUN: begin
                push = s_valid && !full;
                if (de_in) begin
                    if (empty) begin
                        under_d = 1'b1;
                        flush   = 1'b1;
                        state_n = HUNT;
                    end else if (head[PIX_W] != at_origin) begin
                        resync_d = 1'b1;
                        flush    = 1'b1;
                        state_n  = HUNT;
                    end else begin
                        pop   = 1'b1;
                        pix_d = head[PIX_W-1:0];
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    // FIFO storage; stale contents are harmless since pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_sof, s_data};
    end

    // FIFO pointers and occupancy; a flush also drops any same-cycle push.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

    // Input raster tracking: column/row counters, edge history, line length check.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            y_in     <= '0;
            de_d     <= 1'b0;
            vs_d     <= 1'b0;
            geom_err <= 1'b0;
        end else begin
            de_d     <= de_in;
            vs_d     <= vsync_in;
            geom_err <= 1'b0;
            if (de_in) begin
                if (cnt != '1) cnt <= cnt + CW'(1);
            end else if (de_d) begin
                cnt      <= '0;
                geom_err <= (cnt != CW'(H_ACTIVE));
            end
            if (vs_rise)      y_in <= '0;
            else if (de_fall) y_in <= (y_in == YW'(V_ACTIVE - 1)) ? '0 : y_in + YW'(1);
        end
    end

    // Registered outputs to the encoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            data_en   <= 1'b0;
            pixel     <= '0;
            x         <= '0;
            y         <= '0;
            underflow <= 1'b0;
            resync    <= 1'b0;
        end else begin
            hsync     <= hsync_in;
            vsync     <= vsync_in;
            data_en   <= de_in;
            pixel     <= pix_d;
            x         <= cnt[XW-1:0];
            y         <= y_in;
            underflow <= under_d;
            resync    <= resync_d;
        end
    end

endmodule

// File: tb/tb_video_pixel_aligner.sv
// Testbench for video_pixel_aligner: directed scenarios plus randomized frames,
// checked every cycle against a queue-based behavioural model.
module tb_video_pixel_aligner;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int PW = 24;
    localparam int D  = 4;

    localparam int M_HUNT  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          hsync_in, vsync_in, de_in;
    logic          s_valid, s_ready, s_sof;
    logic [PW-1:0] s_data;
    logic          hsync, vsync, data_en;
    logic [PW-1:0] pixel;
    logic [1:0]    x;
    logic [0:0]    y;
    logic          underflow, resync, geom_err;

    always #5 clk = ~clk;

    video_pixel_aligner #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .PIX_W     (PW),
        .FIFO_DEPTH(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .de_in    (de_in),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sof    (s_sof),
        .hsync    (hsync),
        .vsync    (vsync),
        .data_en  (data_en),
        .pixel    (pixel),
        .x        (x),
        .y        (y),
        .underflow(underflow),
        .resync   (resync),
        .geom_err (geom_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    bit [PW:0] m_q[$];
    int        m_mode;
    int        m_col, m_row;
    bit        m_de_d, m_vs_d;
    bit        m_acc;
    bit        e_hs, e_vs, e_de, e_un, e_rs, e_ge;
    int        e_pix, e_x, e_y;

    // Observations from the DUT for directed checks
    int seen_pix[$];
    int seen_x[$];
    int cnt_un, cnt_rs, cnt_ge;

    // Source state
    bit src_on  = 0;
    int src_pct = 100;
    bit src_spur = 0;
    int src_p = 0;
    int src_frame = 0;

    function automatic bit model_ready();
        if (rst) return 1'b0;
        if (m_mode == M_HUNT) return 1'b1;
        return m_q.size() < D;
    endfunction

    task automatic model_update();
        int  pre_mode;
        bit  flush, vs_rise;
        if (rst) begin
            m_q.delete();
            m_mode = M_HUNT;
            m_col = 0; m_row = 0; m_de_d = 0; m_vs_d = 0;
            e_hs = 0; e_vs = 0; e_de = 0; e_un = 0; e_rs = 0; e_ge = 0;
            e_pix = 0; e_x = 0; e_y = 0;
            return;
        end
        pre_mode = m_mode;
        vs_rise  = vsync_in && !m_vs_d;
        e_hs = hsync_in; e_vs = vsync_in; e_de = de_in;
        e_pix = 0; e_un = 0; e_rs = 0; e_ge = 0;
        e_x = m_col % H; e_y = m_row;
        flush = 0;
        if (pre_mode == M_RUN && de_in) begin
            if (m_q.size() == 0) begin
                e_un = 1; flush = 1;
            end else if (m_q[0][PW] != (m_col == 0 && m_row == 0)) begin
                e_rs = 1; flush = 1;
            end else begin
                e_pix = int'(m_q[0][PW-1:0]);
                void'(m_q.pop_front());
            end
        end
        if (flush) begin
            m_q.delete();
            m_mode = M_HUNT;
        end else if (m_acc) begin
            if (pre_mode == M_HUNT) begin
                if (s_sof) begin
                    m_q.push_back({1'b1, s_data});
                    m_mode = M_ARMED;
                end
            end else begin
                m_q.push_back({s_sof, s_data});
            end
        end
        if (pre_mode == M_ARMED && vs_rise) m_mode = M_RUN;
        if (de_in) m_col++;
        else if (m_de_d) begin
            e_ge  = (m_col != H);
            m_col = 0;
            m_row = (m_row + 1) % V;
        end
        if (vs_rise) m_row = 0;
        m_de_d = de_in;
        m_vs_d = vsync_in;
    endtask

    // One clock: inputs are already driven (just after negedge)
    task automatic step();
        bit rdy;
        #1;
        rdy = model_ready();
        check_eq("s_ready", 32'(s_ready), 32'(rdy));
        m_acc = s_valid && rdy;
        model_update();
        @(posedge clk);
        #1;
        check_eq("hsync",     32'(hsync),     32'(e_hs));
        check_eq("vsync",     32'(vsync),     32'(e_vs));
        check_eq("data_en",   32'(data_en),   32'(e_de));
        check_eq("pixel",     32'(pixel),     32'(e_pix));
        check_eq("underflow", 32'(underflow), 32'(e_un));
        check_eq("resync",    32'(resync),    32'(e_rs));
        check_eq("geom_err",  32'(geom_err),  32'(e_ge));
        if (e_de) begin
            check_eq("x", 32'(x), 32'(e_x));
            check_eq("y", 32'(y), 32'(e_y));
        end
        if (data_en) begin
            seen_pix.push_back(int'(pixel));
            seen_x.push_back(int'(x));
        end
        if (underflow) cnt_un++;
        if (resync)    cnt_rs++;
        if (geom_err)  cnt_ge++;
        @(negedge clk);
    endtask

    task automatic tick();
        if (src_on && $urandom_range(99) < src_pct) begin
            s_valid = 1'b1;
            s_data  = PW'(((src_frame & 255) << 8) | (src_p + 1));
            s_sof   = (src_p == 0) || (src_spur && $urandom_range(39) == 0);
        end else begin
            s_valid = 1'b0;
            s_data  = PW'($urandom);
            s_sof   = 1'($urandom);
        end
        step();
        if (src_on && m_acc) begin
            src_p = (src_p + 1) % (H * V);
            if (src_p == 0) src_frame++;
        end
    endtask

    task automatic beat(input int d, input bit sof);
        s_valid = 1'b1;
        s_data  = PW'(d);
        s_sof   = sof;
        step();
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic line(input int n, input int gap);
        de_in = 1'b1;
        repeat (n) tick();
        de_in = 1'b0;
        hsync_in = 1'b1;
        tick();
        hsync_in = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic vblank(input int w, input int back);
        vsync_in = 1'b1;
        repeat (w) tick();
        vsync_in = 1'b0;
        repeat (back) tick();
    endtask

    task automatic clear_obs();
        seen_pix.delete();
        seen_x.delete();
        cnt_un = 0; cnt_rs = 0; cnt_ge = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        de_in = 1'b0; vsync_in = 1'b0; hsync_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hsync_in = 0; vsync_in = 0; de_in = 0;
        s_valid = 0; s_data = '0; s_sof = 0;
        clear_obs();

        // Reset state
        tick(); tick();
        check_eq("rst_data_en", 32'(data_en), 32'd0);
        check_eq("rst_pixel",   32'(pixel),   32'd0);
        check_eq("rst_flags",   32'({underflow, resync, geom_err}), 32'd0);
        rst = 1'b0;
        #1 check_eq("rst_s_ready", 32'(s_ready), 32'd1);

        // Hunt: non-sof beats dropped, sof arms; de before vsync emits zeros
        beat(32'hA, 0); beat(32'hB, 0); beat(32'hC, 0); beat(1, 1);
        clear_obs();
        de_in = 1'b1; tick(); tick(); de_in = 1'b0; tick();
        check_eq("armed_cnt", 32'(seen_pix.size()), 32'd2);
        check_eq("armed_pix", 32'(seen_pix[0] | seen_pix[1]), 32'd0);

        // Locked frame: pixels 1..8 in order
        src_on = 1; src_pct = 100; src_p = 1; src_frame = 0;
        idle(4);
        vblank(2, 2);
        clear_obs();
        line(H, 3); line(H, 3);
        check_eq("lock_cnt", 32'(seen_pix.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq("lock_pix", 32'(seen_pix[i]), 32'(i + 1));
            check_eq("lock_x",   32'(seen_x[i]),   32'(i % H));
        end
        check_eq("lock_errs", 32'(cnt_un + cnt_rs + cnt_ge), 32'd0);

        // Reset in the middle of a running line, then re-lock
        vblank(2, 2);
        de_in = 1'b1; tick(); tick();
        do_reset();
        check_eq("mid_rst_de",  32'(data_en), 32'd0);
        check_eq("mid_rst_pix", 32'(pixel),   32'd0);
        #1 check_eq("mid_rst_rdy", 32'(s_ready), 32'd1);
        clear_obs();
        vblank(2, 2); line(H, 3); line(H, 3);
        vblank(2, 2); line(H, 3); line(H, 3);
        check_eq("relock_errs", 32'(cnt_un + cnt_rs + cnt_ge), 32'd0);

        // Underflow after the stream stalls
        src_on = 0;
        do_reset();
        beat(1, 1); beat(2, 0);
        vblank(2, 2);
        clear_obs();
        line(H, 3);
        check_eq("uf_cnt", 32'(seen_pix.size()), 32'd4);
        check_eq("uf_p0", 32'(seen_pix[0]), 32'd1);
        check_eq("uf_p1", 32'(seen_pix[1]), 32'd2);
        check_eq("uf_p2", 32'(seen_pix[2]), 32'd0);
        check_eq("uf_pulses", 32'(cnt_un), 32'd1);
        check_eq("uf_resync", 32'(cnt_rs), 32'd0);

        // Misplaced sof at x=2, then replay that beat as a real sof
        do_reset();
        beat(1, 1); beat(2, 0); beat(3, 1); beat(4, 0);
        vblank(2, 2);
        clear_obs();
        line(H, 3);
        check_eq("rs_p1", 32'(seen_pix[1]), 32'd2);
        check_eq("rs_p2", 32'(seen_pix[2]), 32'd0);
        check_eq("rs_pulses", 32'(cnt_rs), 32'd1);
        check_eq("rs_uf", 32'(cnt_un), 32'd0);
        beat(3, 1); beat(4, 0); beat(5, 0); beat(6, 0);
        vblank(2, 2);
        clear_obs();
        line(H, 3);
        for (int i = 0; i < 4; i++) check_eq("relock_pix", 32'(seen_pix[i]), 32'(i + 3));
        check_eq("relock_errs2", 32'(cnt_un + cnt_rs + cnt_ge), 32'd0);

        // Short line: one geom_err, next line restarts at x=0
        do_reset();
        src_on = 1; src_pct = 100; src_p = 0; src_frame = 0;
        idle(6);
        vblank(2, 2);
        clear_obs();
        line(3, 3); line(H, 3);
        check_eq("geom_pulses", 32'(cnt_ge), 32'd1);
        check_eq("geom_next_x", 32'(seen_x[3]), 32'd0);
        check_eq("geom_next_p", 32'(seen_pix[3]), 32'd4);
        check_eq("geom_other",  32'(cnt_un + cnt_rs), 32'd0);

        // Randomized frames with stalls, odd line lengths, stray sofs, resets
        src_pct = 70; src_spur = 1;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(19) == 0) do_reset();
            vblank($urandom_range(3, 1), $urandom_range(3, 1));
            for (int l = 0; l < V; l++) begin
                int n;
                n = ($urandom_range(9) == 0) ? $urandom_range(6, 2) : H;
                line(n, $urandom_range(4, 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
